// File: rtl/atree_pipe.sv
// Pipelined adder tree: sums 2**LEVELS operands with one registered stage per tree level.
// Optional macro ATREE_ACC_EN adds an accumulator stage that totals tree results over in_last-delimited groups.
module atree_pipe #(
    parameter int IN_WIDTH = 8,
    parameter int LEVELS   = 2,
    parameter int SIGNED   = 0,
    parameter int ACC_BITS = 8,
`ifdef ATREE_ACC_EN
    localparam int ACC_ON  = 1,
`else
    localparam int ACC_ON  = 0,
`endif
    localparam int N       = 1 << LEVELS,
    localparam int OUT_W   = IN_WIDTH + LEVELS + ACC_ON * ACC_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0][IN_WIDTH-1:0] inputs,
    input  logic                       in_valid,
    output logic                       in_ready,
`ifdef ATREE_ACC_EN
    input  logic                       in_last,
`endif
    output logic [OUT_W-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int TREE_W = IN_WIDTH + LEVELS;

    logic [LEVELS:1]   vld_q;
    logic [LEVELS:0]   vin;
    logic [LEVELS+1:1] rdy;
    logic              tail_ready;
    logic [TREE_W-1:0] tree_sum;

    assign vin      = {vld_q, in_valid};
    assign in_ready = rdy[1];

    // A stage may load when empty or when everything downstream of it can move this edge.
    always_comb begin
        rdy           = '0;
        rdy[LEVELS+1] = tail_ready;
        for (int k = LEVELS; k >= 1; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end
    end

`ifdef ATREE_ACC_EN
    logic [LEVELS:1] last_q;
    logic [LEVELS:0] lin;

    assign lin = {last_q, in_last};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
`ifdef ATREE_ACC_EN
            last_q <= '0;
`endif
        end else begin
            for (int k = 1; k <= LEVELS; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vin[k-1];
`ifdef ATREE_ACC_EN
                    last_q[k] <= lin[k-1];
`endif
                end
            end
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : lvl
        localparam int W = IN_WIDTH + k - 1;
        localparam int M = N >> k;

        logic [2*M-1:0][W-1:0] ops;
        logic [M-1:0][W:0]     sum_q;

        if (k == 1) begin : g_src
            assign ops = inputs;
        end else begin : g_src
            assign ops = lvl[k-1].sum_q;
        end

        // Each operand gains one bit (sign or zero) so the pairwise sum is exact.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else if (rdy[k] && vin[k-1]) begin
                for (int j = 0; j < M; j++) begin
                    sum_q[j] <= {(SIGNED != 0) && ops[2*j][W-1], ops[2*j]}
                              + {(SIGNED != 0) && ops[2*j+1][W-1], ops[2*j+1]};
                end
            end
        end

        if (k == LEVELS) begin : g_root
            assign tree_sum = sum_q[0];
        end
    end

`ifdef ATREE_ACC_EN
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] tree_ext;
    logic             out_vld_q;

    assign tree_ext = {{ACC_BITS{(SIGNED != 0) && tree_sum[TREE_W-1]}}, tree_sum};

    // Non-last beats only touch acc, so only a group's last beat waits on a held result.
    assign tail_ready = !lin[LEVELS] || !out_vld_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (out_vld_q && out_ready) begin
                out_vld_q <= 1'b0;
            end
            if (vin[LEVELS] && tail_ready) begin
                if (lin[LEVELS]) begin
                    out_q     <= acc_q + tree_ext;
                    out_vld_q <= 1'b1;
                    acc_q     <= '0;
                end else begin
                    acc_q <= acc_q + tree_ext;
                end
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_vld_q;
`else
    assign tail_ready = out_ready;
    assign out        = tree_sum;
    assign out_valid  = vin[LEVELS];
`endif

endmodule

// File: tb/tb_atree_pipe.sv
// Testbench for atree_pipe: scoreboard-checked sums on LEVELS=2 (unsigned and signed) and LEVELS=4 instances.
`timescale 1ns/1ps
module tb_atree_pipe;

`ifdef ATREE_ACC_EN
    localparam int XW = 8;
`else
    localparam int XW = 0;
`endif
    localparam int OW2 = 10 + XW;
    localparam int OW4 = 12 + XW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0][7:0]  ab_inputs;
    logic             ab_in_valid;
    logic             ab_out_ready;
    logic             a_in_ready, b_in_ready;
    logic [OW2-1:0]   a_out, b_out;
    logic             a_out_valid, b_out_valid;

    logic [15:0][7:0] c_inputs;
    logic             c_in_valid;
    logic             c_in_ready;
    logic             c_out_ready;
    logic [OW4-1:0]   c_out;
    logic             c_out_valid;

`ifdef ATREE_ACC_EN
    logic             ab_in_last;
    logic             c_in_last = 1'b1;
`endif

    atree_pipe #(.IN_WIDTH(8), .LEVELS(2), .SIGNED(0), .ACC_BITS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .inputs(ab_inputs), .in_valid(ab_in_valid), .in_ready(a_in_ready),
`ifdef ATREE_ACC_EN
        .in_last(ab_in_last),
`endif
        .out(a_out), .out_valid(a_out_valid), .out_ready(ab_out_ready));

    atree_pipe #(.IN_WIDTH(8), .LEVELS(2), .SIGNED(1), .ACC_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .inputs(ab_inputs), .in_valid(ab_in_valid), .in_ready(b_in_ready),
`ifdef ATREE_ACC_EN
        .in_last(ab_in_last),
`endif
        .out(b_out), .out_valid(b_out_valid), .out_ready(ab_out_ready));

    atree_pipe #(.IN_WIDTH(8), .LEVELS(4), .SIGNED(0), .ACC_BITS(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .inputs(c_inputs), .in_valid(c_in_valid), .in_ready(c_in_ready),
`ifdef ATREE_ACC_EN
        .in_last(c_in_last),
`endif
        .out(c_out), .out_valid(c_out_valid), .out_ready(c_out_ready));

    typedef struct {
        logic [OW2-1:0] eu;
        logic [OW2-1:0] es;
    } ab_exp_t;

    ab_exp_t        sb_ab[$];
    logic [OW4-1:0] sb_c[$];
    int acc_u = 0, acc_s = 0;
    int checks = 0, errors = 0;
    int run_c = 0, max_run_c = 0;

    logic [7:0] rot [16] = '{8'd23, 8'd47, 8'd88, 8'd79, 8'd98, 8'd52, 8'd93, 8'd89,
                             8'd93, 8'd46, 8'd37, 8'd101, 8'd26, 8'd89, 8'd27, 8'd9};

    function automatic int sum4(input logic [3:0][7:0] v, input bit sgn);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += sgn ? int'($signed(v[i])) : int'(v[i]);
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic pushAb(input logic [3:0][7:0] v, input bit last);
        ab_exp_t e;
        acc_u += sum4(v, 1'b0);
        acc_s += sum4(v, 1'b1);
        if (last) begin
            e.eu = OW2'(acc_u);
            e.es = OW2'(acc_s);
            sb_ab.push_back(e);
            acc_u = 0;
            acc_s = 0;
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is taken.
    task automatic applyStimulus(input logic [3:0][7:0] v, input bit last);
        int t;
        ab_inputs   = v;
        ab_in_valid = 1'b1;
`ifdef ATREE_ACC_EN
        ab_in_last  = last;
`endif
        #1;
        t = 0;
        while (a_in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("accept_ab", 32'(a_in_ready), 32'd1);
        if (a_in_ready === 1'b1) pushAb(v, last);
        @(negedge clk);
        ab_in_valid = 1'b0;
    endtask

    task automatic applyC(input logic [15:0][7:0] v);
        int t;
        int s;
        c_inputs   = v;
        c_in_valid = 1'b1;
        #1;
        t = 0;
        while (c_in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("accept_c", 32'(c_in_ready), 32'd1);
        if (c_in_ready === 1'b1) begin
            s = 0;
            for (int i = 0; i < 16; i++) s += int'(v[i]);
            sb_c.push_back(OW4'(s));
        end
        @(negedge clk);
        c_in_valid = 1'b0;
    endtask

    // Sample one time unit before each rising edge so the handshake seen matches the DUT's.
    always begin : mon_ab
        ab_exp_t e;
        @(negedge clk);
        #4;
        if (rst_n === 1'b1 && a_out_valid === 1'b1 && ab_out_ready === 1'b1) begin
            checkOutput("ab_sb_nonempty", 32'(sb_ab.size() != 0), 32'd1);
            if (sb_ab.size() != 0) begin
                e = sb_ab.pop_front();
                checkOutput("a_out", 32'(a_out), 32'(e.eu));
                checkOutput("b_out", 32'(b_out), 32'(e.es));
                checkOutput("b_out_valid", 32'(b_out_valid), 32'd1);
            end
        end
    end

    always begin : mon_c
        logic [OW4-1:0] e;
        @(negedge clk);
        #4;
        if (rst_n === 1'b1) begin
            if (c_out_valid === 1'b1) begin
                run_c++;
                if (run_c > max_run_c) max_run_c = run_c;
            end else begin
                run_c = 0;
            end
            if (c_out_valid === 1'b1 && c_out_ready === 1'b1) begin
                checkOutput("c_sb_nonempty", 32'(sb_c.size() != 0), 32'd1);
                if (sb_c.size() != 0) begin
                    e = sb_c.pop_front();
                    checkOutput("c_out", 32'(c_out), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [15:0][7:0] cv;
        logic [3:0][7:0]  p1, p2, p3;
        logic [OW2-1:0]   held;

        rst_n        = 1'b0;
        ab_inputs    = '0;
        ab_in_valid  = 1'b0;
        ab_out_ready = 1'b1;
        c_inputs     = '0;
        c_in_valid   = 1'b0;
        c_out_ready  = 1'b1;
`ifdef ATREE_ACC_EN
        ab_in_last   = 1'b0;
`endif
        #3;
        checkOutput("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_a_out", 32'(a_out), 32'd0);
        checkOutput("rst_c_out_valid", 32'(c_out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);

        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) cv[i] = rot[(i + b) % 16];
            applyC(cv);
        end
        repeat (8) @(negedge clk);
        checkOutput("c_consecutive_valid", 32'(max_run_c), 32'd16);

`ifdef ATREE_ACC_EN
        applyStimulus({4{8'h01}}, 1'b0);
        applyStimulus({4{8'h01}}, 1'b0);
        applyStimulus({4{8'h01}}, 1'b1);
        #1;
        checkOutput("acc_lat1", 32'(a_out_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("acc_lat2", 32'(a_out_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("acc_lat3", 32'(a_out_valid), 32'd1);
        checkOutput("acc_group3", 32'(a_out), 32'd12);
        @(negedge clk);
        applyStimulus({4{8'h02}}, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("acc_group1", 32'(a_out), 32'd8);
        repeat (4) @(negedge clk);
`else
        applyStimulus({4{8'hFF}}, 1'b1);
        #1;
        checkOutput("lat_cycle1", 32'(a_out_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("lat_cycle2", 32'(a_out_valid), 32'd1);
        checkOutput("all_ff_sum", 32'(a_out), 32'h3FC);
        @(negedge clk);

        applyStimulus({8'd5, 8'hFF, 8'h7F, 8'h80}, 1'b1);
        @(negedge clk); #1;
        checkOutput("mixed_unsigned", 32'(a_out), 32'h203);
        checkOutput("mixed_signed", 32'(b_out), 32'd3);
        repeat (3) @(negedge clk);

        p1 = {8'd1, 8'd2, 8'd3, 8'd4};
        p2 = {8'd10, 8'd20, 8'd30, 8'd40};
        p3 = {8'hF0, 8'h0F, 8'h80, 8'h01};
        held = OW2'(sum4(p1, 1'b0));
        ab_out_ready = 1'b0;
        applyStimulus(p1, 1'b1);
        applyStimulus(p2, 1'b1);
        ab_inputs   = p3;
        ab_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("stall_in_ready", 32'(a_in_ready), 32'd0);
            checkOutput("stall_hold_out", 32'(a_out), 32'(held));
            @(negedge clk);
        end
        ab_out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(a_out_valid), 32'd1);
        pushAb(p3, 1'b1);
        @(negedge clk);
        ab_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("stall_drained", 32'(sb_ab.size()), 32'd0);

        applyStimulus({8'd9, 8'd9, 8'd9, 8'd9}, 1'b1);
        applyStimulus({8'd7, 8'd7, 8'd7, 8'd7}, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("async_rst_out", 32'(a_out), 32'd0);
        sb_ab.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("post_rst_no_stale", 32'(a_out_valid), 32'd0);
            @(negedge clk);
            #1;
        end
`endif

        $display("[TB] directed sequence complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
